class_select_ctrl: RTL and testbench
====================================

// Module: class_select_ctrl
// PURPOSE
//  Sequential argmax controller at the classifier output of the NN datapath. Output layer streams
//  NUM_CLASSES scores serially via valid/ready. Block tracks the running max and reports the
//  winning class index, with a result handshake. Replaces the wide parallel compare tree when scores arrive serially.
// PARAMETERS
//  NUM_CLASSES  10  scores per frame (>=2)
//  SCORE_W      8   score width, unsigned
//  IDX_W        4   index width, >= clog2(NUM_CLASSES)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        1-cycle pulse: begin a frame (honoured only in IDLE)
//  score_valid    in   1        score beat valid
//  score_data     in   SCORE_W  class score; beat k = class index k
//  score_last     in   1        marks final beat of frame
//  score_ready    out  1        accepting beats (high only in COLLECT)
//  busy           out  1        state != IDLE
//  result_valid   out  1        result held valid until accepted
//  result_ready   in   1        downstream accepts result
//  result_index   out  IDX_W    argmax class index
//  result_score   out  SCORE_W  winning score
//  result_err     out  1        frame framing error (see below)
//  result_margin  out  SCORE_W  only with CLS_MARGIN_EN: best minus second-best
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; internal count/max/idx cleared. Async assert, sync deassert.
//  - FSM: IDLE -start-> COLLECT -final beat accepted-> DONE -result_valid&result_ready-> IDLE.
//  - start during COLLECT/DONE: ignored. score_valid in IDLE/DONE: ignored (score_ready=0).
//  - Beat accepted when score_valid&score_ready. Beat 0 loads max=data, idx=0.
//    Beat k>0: if data >= max then max=data, idx=k. Unsigned compare. Ties go to the HIGHER index.
//  - Frame ends on the accepted beat NUM_CLASSES-1 or on an earlier accepted beat with score_last=1.
//  - result_err=1 if score_last was seen early, or is low on beat NUM_CLASSES-1.
//    Early end: index/score still reflect beats received.
//  - Latency: result_valid rises the cycle after the final beat is accepted. Outputs stay stable until the handshake.
//  - Back-to-back: result handshake returns to IDLE. start in that IDLE cycle begins the next frame,
//    so the minimum frame gap is 1 cycle.
//  - Reset mid-frame: frame dropped, no result produced.
//  - Beat counter saturates at NUM_CLASSES-1. It never wraps.
// CONFIGURATION
//  - CLS_MARGIN_EN defined: also track second-best (data>=max: second=max, max=data;
//    else data>second: second=data). result_margin = max-second, 0 on tie or single-beat frame.
//  - Undefined: no second-best register, no result_margin port.
// STRUCTURE
//  - Package cls_pkg holds the FSM state encoding (IDLE, COLLECT, DONE) and index-width helper function.
//  - Sub-module cls_max_track holds the running max/idx (and second-best) registers with compare.
//    The FSM and handshakes stay in class_select_ctrl.
// TESTING
//  - Frame {3,7,1,9,2,0,4,8,5,6} -> result_index=3, result_score=9, err=0, result_valid 1 cycle after beat 9.
//  - Ties {5,9,9,1,9,0,0,0,0,0} -> index=4 (highest tied), score=9. Margin=0 with CLS_MARGIN_EN.
//  - score_valid toggling every other cycle, and result_ready held low 5 cycles -> same result, outputs stable, no extra beats taken.
//  - score_last on beat 3 of {1,2,8,4} -> index=2, score=8, err=1. score_last missing on beat 9 -> err=1.
//  - rst_n low after beat 4 -> all outputs 0, IDLE. Next full frame processed correctly.
//  - Frame {0,200,...,190,...} with CLS_MARGIN_EN -> margin=10. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/cls_pkg.sv
// ---------------------------------------------------------------------------
// cls_pkg
// Shared definitions for the serial argmax controller (class_select_ctrl).
//   cls_state_e : FSM state encoding (IDLE / COLLECT / DONE)
//   cls_idx_w() : minimum index width needed to count a given number of classes
// ---------------------------------------------------------------------------
package cls_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } cls_state_e;

   // Bits needed to hold indices 0..n-1 (at least 1 bit).
   function automatic int cls_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cls_max_track.sv
// ---------------------------------------------------------------------------
// cls_max_track
// Running maximum / argmax registers for the serial class selector.
// Optional build macro: CLS_MARGIN_EN adds a second-best register and the
// margin_o output (best minus second-best).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   beat_i        : a score beat is accepted this cycle
//   first_i       : the accepted beat is beat 0 of the frame
//   idx_i         : class index of the accepted beat
//   data_i        : score of the accepted beat (unsigned)
//   max_o, idx_o  : running best score and its class index
//   margin_o      : (CLS_MARGIN_EN only) best minus second-best, 0 if none
// ---------------------------------------------------------------------------
module cls_max_track #(
   parameter int SCORE_W = 8,
   parameter int IDX_W   = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               beat_i,
   input  logic               first_i,
   input  logic [IDX_W-1:0]   idx_i,
   input  logic [SCORE_W-1:0] data_i,
   output logic [SCORE_W-1:0] max_o,
   output logic [IDX_W-1:0]   idx_o
`ifdef CLS_MARGIN_EN
   ,
   output logic [SCORE_W-1:0] margin_o
`endif
);

   logic [SCORE_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   // >= so that ties move the winner to the later (higher) index.
   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      if (beat_i && (first_i || data_i >= max_q)) begin
         max_d = data_i;
         idx_d = idx_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign max_o = max_q;
   assign idx_o = idx_q;

`ifdef CLS_MARGIN_EN
   logic [SCORE_W-1:0] sec_q, sec_d;
   logic               sec_vld_q, sec_vld_d;

   // sec_vld marks that a second beat exists; a single-beat frame has no
   // runner-up and reports margin 0.
   always_comb begin
      sec_d     = sec_q;
      sec_vld_d = sec_vld_q;
      if (beat_i) begin
         if (first_i) begin
            sec_d     = '0;
            sec_vld_d = 1'b0;
         end else if (data_i >= max_q) begin
            sec_d     = max_q;
            sec_vld_d = 1'b1;
         end else if (!sec_vld_q || data_i > sec_q) begin
            sec_d     = data_i;
            sec_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sec_q     <= '0;
         sec_vld_q <= 1'b0;
      end else begin
         sec_q     <= sec_d;
         sec_vld_q <= sec_vld_d;
      end
   end

   assign margin_o = sec_vld_q ? (max_q - sec_q) : '0;
`endif

endmodule

// File: rtl/class_select_ctrl.sv
// ---------------------------------------------------------------------------
// class_select_ctrl
// Sequential argmax controller: consumes NUM_CLASSES serial scores per frame
// (beat k = class k) and reports the winning class with a result handshake.
// Optional build macro: CLS_MARGIN_EN adds result_margin_o.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   start_i                  : 1-cycle frame start, honoured only in IDLE
//   score_valid_i/_data_i/_last_i, score_ready_o : score stream
//   busy_o                   : controller not in IDLE
//   result_valid_o/ready_i   : result handshake
//   result_index_o/score_o   : argmax index and winning score
//   result_err_o             : framing error (early or missing last)
//   result_margin_o          : (CLS_MARGIN_EN only) best minus second-best
// ---------------------------------------------------------------------------
module class_select_ctrl
   import cls_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 8,
   parameter int IDX_W       = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               score_valid_i,
   input  logic [SCORE_W-1:0] score_data_i,
   input  logic               score_last_i,
   output logic               score_ready_o,
   output logic               busy_o,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [IDX_W-1:0]   result_index_o,
   output logic [SCORE_W-1:0] result_score_o,
   output logic               result_err_o
`ifdef CLS_MARGIN_EN
   ,
   output logic [SCORE_W-1:0] result_margin_o
`endif
);

   localparam int               CNT_W  = cls_idx_w(NUM_CLASSES);
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_CLASSES - 1);

   cls_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic beat_acc, at_last, frame_end;

   assign beat_acc  = score_valid_i & score_ready_o;
   assign at_last   = (cnt_q == LAST_K);
   assign frame_end = beat_acc & (at_last | score_last_i);

   // ---------------- state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_i)        state_d = ST_COLLECT;
         ST_COLLECT: if (frame_end)      state_d = ST_DONE;
         ST_DONE:    if (result_ready_i) state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      score_ready_o  = (state_q == ST_COLLECT);
      busy_o         = (state_q != ST_IDLE);
      result_valid_o = (state_q == ST_DONE);
   end

   // Beat counter: cleared by an honoured start, saturates on the last class.
   // Error flag is latched on the beat that ends the frame: last must coincide
   // exactly with beat NUM_CLASSES-1.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == ST_IDLE && start_i) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if (beat_acc) begin
         if (!at_last) cnt_d = cnt_q + 1'b1;
         if (frame_end) err_d = score_last_i ^ at_last;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   cls_max_track #(
      .SCORE_W (SCORE_W),
      .IDX_W   (IDX_W)
   ) u_track (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .beat_i   (beat_acc),
      .first_i  (cnt_q == '0),
      .idx_i    (IDX_W'(cnt_q)),
      .data_i   (score_data_i),
      .max_o    (result_score_o),
      .idx_o    (result_index_o)
`ifdef CLS_MARGIN_EN
      ,
      .margin_o (result_margin_o)
`endif
   );

   assign result_err_o = err_q;

endmodule

// File: tb/tb_class_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_class_select_ctrl
// Directed frames with hand-computed results. The driver pushes the expected
// result into a queue; a monitor pops and compares on each result handshake
// and also checks that held results stay stable.
// ---------------------------------------------------------------------------
module tb_class_select_ctrl;

   typedef logic [7:0] frame_t [10];
   typedef struct packed {
      logic [3:0] idx;
      logic [7:0] sc;
      logic       err;
      logic [7:0] mg;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       start_i, score_valid_i, score_last_i, result_ready_i;
   logic [7:0] score_data_i;
   logic       score_ready_o, busy_o, result_valid_o, result_err_o;
   logic [3:0] result_index_o;
   logic [7:0] result_score_o;
`ifdef CLS_MARGIN_EN
   logic [7:0] result_margin_o;
`endif

   always #5 clk = ~clk;

   class_select_ctrl #(.NUM_CLASSES(10), .SCORE_W(8), .IDX_W(4)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .score_valid_i  (score_valid_i),
      .score_data_i   (score_data_i),
      .score_last_i   (score_last_i),
      .score_ready_o  (score_ready_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_index_o (result_index_o),
      .result_score_o (result_score_o),
      .result_err_o   (result_err_o)
`ifdef CLS_MARGIN_EN
      ,
      .result_margin_o(result_margin_o)
`endif
   );

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- monitor ----------------
   logic       pv = 1'b0;
   logic [3:0] pi;
   logic [7:0] ps;
   logic       pe;

   always @(negedge clk) begin
      if (!rst_ni) begin
         pv = 1'b0;
      end else begin
         if (pv) begin
            chk("hold_valid", {31'd0, result_valid_o}, 32'd1);
            chk("hold_index", {28'd0, result_index_o}, {28'd0, pi});
            chk("hold_score", {24'd0, result_score_o}, {24'd0, ps});
            chk("hold_err",   {31'd0, result_err_o},   {31'd0, pe});
         end
         if (result_valid_o && result_ready_i) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result_index", {28'd0, result_index_o}, {28'd0, e.idx});
               chk("result_score", {24'd0, result_score_o}, {24'd0, e.sc});
               chk("result_err",   {31'd0, result_err_o},   {31'd0, e.err});
`ifdef CLS_MARGIN_EN
               chk("result_margin", {24'd0, result_margin_o}, {24'd0, e.mg});
`endif
            end
            pv = 1'b0;
         end else begin
            pv = result_valid_o;
            pi = result_index_o;
            ps = result_score_o;
            pe = result_err_o;
         end
      end
   end

   // ---------------- driver helpers ----------------
   // Holds the current beat until it is sampled with score_ready high.
   task automatic wait_accept(output bit ok);
      bit r;
      ok = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk); r = score_ready_o;
         @(posedge clk); #1;
         if (r) begin ok = 1'b1; break; end
      end
      if (!ok) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_frame(input frame_t s, input int n, input int last_at,
                            input bit slow, input int hold,
                            input logic [3:0] ei, input logic [7:0] es,
                            input logic ee, input logic [7:0] em);
      exp_t e;
      bit   ok, r;
      e.idx = ei; e.sc = es; e.err = ee; e.mg = em;
      q.push_back(e);
      start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (slow) begin
            score_valid_i = 1'b0;
            start_i = (k == 2);   // start while busy must be ignored
            @(posedge clk); #1 start_i = 1'b0;
         end
         score_valid_i = 1'b1;
         score_data_i  = s[k];
         score_last_i  = (k == last_at);
         wait_accept(ok);
         if (!ok) return;
      end
      chk("latency_valid", {31'd0, result_valid_o}, 32'd1);
      chk("ready_low_in_done", {31'd0, score_ready_o}, 32'd0);
      if (slow) begin
         // junk beats offered while DONE must not be taken
         score_valid_i = 1'b1; score_data_i = 8'hFF; score_last_i = 1'b1;
      end else begin
         score_valid_i = 1'b0; score_last_i = 1'b0;
      end
      for (int c = 0; c < hold; c++) begin
         start_i = slow && (c == 1);
         @(posedge clk); #1;
      end
      start_i = 1'b0; score_valid_i = 1'b0; score_last_i = 1'b0;
      result_ready_i = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk); r = result_valid_o;
         @(posedge clk); #1;
         if (r) begin ok = 1'b1; break; end
      end
      result_ready_i = 1'b0;
      if (!ok) chk("result_timeout", 32'd0, 32'd1);
      chk("idle_after_handshake", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  {31'd0, busy_o},         32'd0);
      chk({tag, "_ready"}, {31'd0, score_ready_o},  32'd0);
      chk({tag, "_valid"}, {31'd0, result_valid_o}, 32'd0);
      chk({tag, "_index"}, {28'd0, result_index_o}, 32'd0);
      chk({tag, "_score"}, {24'd0, result_score_o}, 32'd0);
      chk({tag, "_err"},   {31'd0, result_err_o},   32'd0);
`ifdef CLS_MARGIN_EN
      chk({tag, "_margin"}, {24'd0, result_margin_o}, 32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      frame_t f1, ft, fe, fd, fm, f1b;
      bit ok;
      f1  = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd0, 8'd4, 8'd8, 8'd5, 8'd6};
      ft  = '{8'd5, 8'd9, 8'd9, 8'd1, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      fe  = '{8'd1, 8'd2, 8'd8, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      fd  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      fm  = '{8'd0, 8'd200, 8'd10, 8'd20, 8'd190, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
      f1b = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

      rst_ni = 1'b0; start_i = 1'b0; score_valid_i = 1'b0; score_last_i = 1'b0;
      score_data_i = 8'd0; result_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #2 chk_zero("reset");
      @(posedge clk); #1 rst_ni = 1'b1;
      @(posedge clk); #1;

      // basic frame, immediate acceptance
      run_frame(f1, 10, 9, 1'b0, 0, 4'd3, 8'd9, 1'b0, 8'd1);
      // ties go to the highest index; starts in the first IDLE cycle
      run_frame(ft, 10, 9, 1'b0, 0, 4'd4, 8'd9, 1'b0, 8'd0);
      // throttled beats, result held 5 cycles, stray starts
      run_frame(f1, 10, 9, 1'b1, 5, 4'd3, 8'd9, 1'b0, 8'd1);
      // early last on beat 3
      run_frame(fe, 4, 3, 1'b0, 0, 4'd2, 8'd8, 1'b1, 8'd4);
      // missing last on beat 9
      run_frame(f1, 10, -1, 1'b0, 2, 4'd3, 8'd9, 1'b1, 8'd1);
      // single-beat frame (early end on beat 0)
      run_frame(f1b, 1, 0, 1'b0, 0, 4'd0, 8'd7, 1'b1, 8'd0);

      // reset in the middle of a frame: dropped, no result
      start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         score_valid_i = 1'b1; score_data_i = fd[k]; score_last_i = 1'b0;
         wait_accept(ok);
      end
      score_valid_i = 1'b0;
      rst_ni = 1'b0;
      #2 chk_zero("midreset");
      @(posedge clk); #1 rst_ni = 1'b1;
      @(posedge clk); #1;

      // descending frame after reset, winner at index 0
      run_frame(fd, 10, 9, 1'b0, 0, 4'd0, 8'd9, 1'b0, 8'd1);
      // wide scores, margin 200-190
      run_frame(fm, 10, 9, 1'b0, 1, 4'd1, 8'd200, 1'b0, 8'd10);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
